// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction timer: state encoding, widths, LFSR taps.
package rt_pkg;

  localparam int unsigned MS_W    = 14;
  localparam int unsigned LFSR_W  = 12;
  localparam int unsigned DELAY_W = 13;

  // Fibonacci taps 12,11,10,4 mapped onto bits 11,10,9,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 12'hE08;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRun,
    StDone,
    StCheat
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rt_lfsr.sv
// Free-running 12-bit maximal-length Fibonacci LFSR, reloaded with Seed on reset.
module rt_lfsr
  import rt_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic [LFSR_W-1:0] Seed,
  output logic [LFSR_W-1:0] Value
);

  logic [LFSR_W-1:0] value_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      value_q <= Seed;
    end else begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign Value = value_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer round controller: random wait, stimulus lamp, reaction count, cheat/timeout.
// Define BEST_TIME_EN to build the best (minimum) valid reaction time register.
module reaction_timer_ctrl
  import rt_pkg::*;
#(
  parameter int unsigned       MIN_DELAY_MS = 1000,
  parameter int unsigned       MAX_MS       = 9999,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 12'hACE
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            MsClk,
  input  logic            Start,
  input  logic            React,
  output logic            Led,
  output logic            Done,
  output logic            Cheat,
  output logic            Timeout,
  output logic [MS_W-1:0] ReactMs,
  output logic [MS_W-1:0] BestMs
);

  localparam logic [MS_W-1:0]    MaxMs   = MS_W'(MAX_MS);
  localparam logic [MS_W-1:0]    MaxMsM1 = MS_W'(MAX_MS - 1);
  localparam logic [DELAY_W-1:0] MinDly  = DELAY_W'(MIN_DELAY_MS);

  logic start_s1_q, start_s2_q, start_prev_q;
  logic react_s1_q, react_s2_q, react_prev_q;
  logic ms_s1_q, ms_prev_q;
  logic start_edge, react_edge, tick;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_prev_q <= 1'b0;
      react_s1_q   <= 1'b0;
      react_s2_q   <= 1'b0;
      react_prev_q <= 1'b0;
      ms_s1_q      <= 1'b0;
      ms_prev_q    <= 1'b0;
    end else begin
      start_s1_q   <= Start;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
      react_s1_q   <= React;
      react_s2_q   <= react_s1_q;
      react_prev_q <= react_s2_q;
      ms_s1_q      <= MsClk;
      ms_prev_q    <= ms_s1_q;
    end
  end

  assign start_edge = start_s2_q & ~start_prev_q;
  assign react_edge = react_s2_q & ~react_prev_q;
  assign tick       = ms_s1_q & ~ms_prev_q;

  logic [LFSR_W-1:0] lfsr_value;

  rt_lfsr u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .Seed  (LFSR_SEED),
    .Value (lfsr_value)
  );

  state_e             state_q, state_d;
  logic               led_q, led_d;
  logic               done_q, done_d;
  logic               cheat_q, cheat_d;
  logic               timeout_q, timeout_d;
  logic [MS_W-1:0]    react_ms_q, react_ms_d;
  logic [DELAY_W-1:0] delay_q, delay_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      led_q      <= 1'b0;
      done_q     <= 1'b0;
      cheat_q    <= 1'b0;
      timeout_q  <= 1'b0;
      react_ms_q <= '0;
      delay_q    <= '0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      done_q     <= done_d;
      cheat_q    <= cheat_d;
      timeout_q  <= timeout_d;
      react_ms_q <= react_ms_d;
      delay_q    <= delay_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    done_d     = done_q;
    cheat_d    = cheat_q;
    timeout_d  = timeout_q;
    react_ms_d = react_ms_q;
    delay_d    = delay_q;

    unique case (state_q)
      StIdle, StDone, StCheat: begin
        if (start_edge) begin
          state_d    = StWait;
          delay_d    = MinDly + DELAY_W'(lfsr_value);
          led_d      = 1'b0;
          done_d     = 1'b0;
          cheat_d    = 1'b0;
          timeout_d  = 1'b0;
          react_ms_d = '0;
        end
      end
      StWait: begin
        // A press always beats a coincident expiry tick
        if (react_edge) begin
          state_d = StCheat;
          cheat_d = 1'b1;
        end else if (tick) begin
          delay_d = delay_q - DELAY_W'(1);
          if (delay_q == DELAY_W'(1)) begin
            state_d    = StRun;
            led_d      = 1'b1;
            react_ms_d = '0;
          end
        end
      end
      StRun: begin
        if (react_edge) begin
          state_d = StDone;
          done_d  = 1'b1;
          led_d   = 1'b0;
        end else if (tick) begin
          if (react_ms_q >= MaxMsM1) begin
            state_d    = StDone;
            react_ms_d = MaxMs;
            timeout_d  = 1'b1;
            led_d      = 1'b0;
          end else begin
            react_ms_d = react_ms_q + MS_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef BEST_TIME_EN
  logic [MS_W-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (state_q == StRun && react_edge && react_ms_q < best_q) begin
      best_d = react_ms_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      best_q <= MaxMs;
    end else begin
      best_q <= best_d;
    end
  end

  assign BestMs = best_q;
`else
  assign BestMs = '0;
`endif

  assign Led     = led_q;
  assign Done    = done_q;
  assign Cheat   = cheat_q;
  assign Timeout = timeout_q;
  assign ReactMs = react_ms_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed self-checking bench for reaction_timer_ctrl; the bench owns MsClk so ticks are exact.
module tb_reaction_timer_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic MsClk = 1'b0;
  logic Start = 1'b0;
  logic React = 1'b0;
  logic StartB = 1'b0;
  logic ReactB = 1'b0;

  logic        led, done, cheat, timeout;
  logic [13:0] react_ms, best_ms;
  logic        led_b, done_b, cheat_b, timeout_b;
  logic [13:0] react_ms_b, best_ms_b;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_delay;

  logic [11:0] lfsr_m;

  always #5 Clk = ~Clk;

  // Seed 0 locks the LFSR, so every wait is exactly MIN_DELAY_MS ticks
  reaction_timer_ctrl #(
    .MIN_DELAY_MS (1000),
    .MAX_MS       (9999),
    .LFSR_SEED    (12'h000)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .MsClk   (MsClk),
    .Start   (Start),
    .React   (React),
    .Led     (led),
    .Done    (done),
    .Cheat   (cheat),
    .Timeout (timeout),
    .ReactMs (react_ms),
    .BestMs  (best_ms)
  );

  reaction_timer_ctrl dut_b (
    .Clk     (Clk),
    .Rst     (Rst),
    .MsClk   (MsClk),
    .Start   (StartB),
    .React   (ReactB),
    .Led     (led_b),
    .Done    (done_b),
    .Cheat   (cheat_b),
    .Timeout (timeout_b),
    .ReactMs (react_ms_b),
    .BestMs  (best_ms_b)
  );

  // Reference LFSR for dut_b: x^12 + x^11 + x^10 + x^4, shifting left
  always @(posedge Clk) begin
    if (Rst) lfsr_m <= 12'hACE;
    else     lfsr_m <= {lfsr_m[10:0], lfsr_m[11] ^ lfsr_m[10] ^ lfsr_m[9] ^ lfsr_m[3]};
  end

  function automatic int unsigned best_exp(input int unsigned v);
`ifdef BEST_TIME_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk) MsClk = 1'b1;
      @(negedge Clk) MsClk = 1'b0;
    end
    @(negedge Clk);
  endtask

  task automatic press_start();
    @(negedge Clk) Start = 1'b1;
    repeat (3) @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic press_react();
    @(negedge Clk) React = 1'b1;
    repeat (3) @(negedge Clk);
    React = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  // React edge and tick land on the same cycle
  task automatic react_with_tick();
    @(negedge Clk) React = 1'b1;
    @(negedge Clk) MsClk = 1'b1;
    @(negedge Clk) MsClk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic round(input int n, input int unsigned best);
    press_start();
    ticks(400);
    press_start();
    ticks(599);
    check("round_led_pre", led, 0);
    ticks(1);
    check("round_led_on", led, 1);
    ticks(n);
    press_react();
    check("round_react_ms", react_ms, n);
    check("round_done", done, 1);
    check("round_best", best_ms, best_exp(best));
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    check("rst_led", led, 0);
    check("rst_done", done, 0);
    check("rst_cheat", cheat, 0);
    check("rst_timeout", timeout, 0);
    check("rst_react_ms", react_ms, 0);
    check("rst_best", best_ms, best_exp(9999));

    // Random wait on the default-seed instance
    @(negedge Clk) StartB = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1 exp_delay = 1000 + int'(lfsr_m);
    @(negedge Clk);
    @(negedge Clk);
    StartB = 1'b0;
    ticks(exp_delay - 1);
    check("rand_led_pre", led_b, 0);
    ticks(1);
    check("rand_led_on", led_b, 1);

    // Fixed 1000-tick wait, 237 ms reaction
    press_start();
    check("wait_led", led, 0);
    ticks(999);
    check("wait999_led", led, 0);
    ticks(1);
    check("run_led", led, 1);
    check("run_react_ms0", react_ms, 0);
    ticks(237);
    check("run_react_ms237", react_ms, 237);
    press_react();
    check("done_flag", done, 1);
    check("done_react_ms", react_ms, 237);
    check("done_led", led, 0);
    check("done_timeout", timeout, 0);
    press_react();
    check("done_react_ignored", react_ms, 237);

    // Early press in WAIT
    press_start();
    check("new_round_done", done, 0);
    check("new_round_react_ms", react_ms, 0);
    ticks(500);
    press_react();
    check("cheat_flag", cheat, 1);
    check("cheat_led", led, 0);
    check("cheat_react_ms", react_ms, 0);
    ticks(600);
    check("cheat_led_hold", led, 0);
    check("cheat_hold", cheat, 1);

    // Start ignored in RUN; React coincident with tick at 99
    press_start();
    check("cheat_cleared", cheat, 0);
    ticks(1000);
    check("run2_led", led, 1);
    ticks(50);
    press_start();
    check("run_start_ign_led", led, 1);
    check("run_start_ign_ms", react_ms, 50);
    ticks(49);
    check("run_react_ms99", react_ms, 99);
    react_with_tick();
    React = 1'b0;
    repeat (2) @(negedge Clk);
    check("coinc_react_ms", react_ms, 99);
    check("coinc_done", done, 1);
    check("coinc_best", best_ms, best_exp(99));

    // Reset mid-RUN
    press_start();
    ticks(1000);
    ticks(250);
    check("mid_react_ms", react_ms, 250);
    @(negedge Clk) Rst = 1'b1;
    @(negedge Clk) Rst = 1'b0;
    check("midrst_react_ms", react_ms, 0);
    check("midrst_led", led, 0);
    check("midrst_done", done, 0);
    check("midrst_best", best_ms, best_exp(9999));
    ticks(3);
    check("idle_react_ms", react_ms, 0);
    check("idle_led", led, 0);

    round(300, 300);
    round(180, 180);
    round(410, 180);

    // No press: saturate at MAX_MS
    press_start();
    ticks(1000);
    ticks(9998);
    check("to_react_ms9998", react_ms, 9998);
    check("to_timeout_pre", timeout, 0);
    ticks(1);
    check("to_react_ms", react_ms, 9999);
    check("to_timeout", timeout, 1);
    check("to_done", done, 0);
    ticks(3);
    check("to_saturate", react_ms, 9999);
    check("to_best", best_ms, best_exp(180));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
